bram_access_ctrl: RTL and testbench

Initiator-side controller that drives the read/write ports of a 1-read/1-write synchronous RAM. The RAM has 1-cycle read latency and returns old data when a read and a write hit the same address on the same edge.
After reset it zero-fills the RAM, then serves valid/ready read requests and fire-and-forget writes. It returns read data through a 2-entry response buffer that supports backpressure, and forwards same-cycle write data so every read returns the newest value.
It sits between pipeline clients (e.g. LSU, table updaters) and the RAM macro.

---
 rtl/bram_access_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_bram_access_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_access_ctrl.sv
// ---------------------------------------------------------------------------
// bram_access_ctrl
//
// Initiator-side controller for a 1-read/1-write synchronous RAM with a
// 1-cycle read latency and old-data-on-collision behaviour.
//
// After reset it fills every entry with INIT_VALUE. It then serves valid/ready
// read requests and fire-and-forget writes. Read data comes back through a
// 2-entry in-order response buffer that honours consumer backpressure. A write
// that hits the same address as a read accepted in the same cycle is forwarded,
// so every read returns the newest value.
//
// Ports:
//   clk            clock, all state on the rising edge
//   reset_n        asynchronous active-low reset
//   init_busy      high while the init fill runs
//   rd_req_valid   read request valid
//   rd_req_ready   controller accepts the read request
//   rd_req_addr    read address
//   rd_resp_valid  response data valid
//   rd_resp_ready  consumer accepts the response
//   rd_resp_data   response data
//   wr_valid       write request
//   wr_ready       write accepted this cycle
//   wr_addr        write address
//   wr_data        write data
//   mem_raddr      RAM read address
//   mem_rdata      RAM read data, valid one cycle after mem_raddr
//   mem_waddr      RAM write address
//   mem_wdata      RAM write data
//   mem_we         RAM write enable
// ---------------------------------------------------------------------------
module bram_access_ctrl #(
  parameter int BRAM_ADDR_WIDTH = 5,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int DATA_DEPTH      = 32,
  parameter logic [BRAM_DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       init_busy,
  input  logic                       rd_req_valid,
  output logic                       rd_req_ready,
  input  logic [BRAM_ADDR_WIDTH-1:0] rd_req_addr,
  output logic                       rd_resp_valid,
  input  logic                       rd_resp_ready,
  output logic [BRAM_DATA_WIDTH-1:0] rd_resp_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [BRAM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] wr_data,
  output logic [BRAM_ADDR_WIDTH-1:0] mem_raddr,
  input  logic [BRAM_DATA_WIDTH-1:0] mem_rdata,
  output logic [BRAM_ADDR_WIDTH-1:0] mem_waddr,
  output logic [BRAM_DATA_WIDTH-1:0] mem_wdata,
  output logic                       mem_we
);

  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_IDX = BRAM_ADDR_WIDTH'(DATA_DEPTH - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [BRAM_ADDR_WIDTH-1:0]   init_cnt;

  logic                         rd_accept;
  logic                         s1_valid;
  logic                         fwd;
  logic [BRAM_DATA_WIDTH-1:0]   fwd_data;
  logic [BRAM_DATA_WIDTH-1:0]   capture_data;

  logic [BRAM_DATA_WIDTH-1:0]   fifo_mem [2];
  logic                         fifo_rd_ptr;
  logic                         fifo_wr_ptr;
  logic [1:0]                   fifo_occ;
  logic                         push;
  logic                         pop;
  logic [2:0]                   pending;

  // State register and init counter. The counter walks every RAM entry once
  // while in INIT and then freezes; only reset brings the FSM back to INIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) begin
        init_cnt <= init_cnt + BRAM_ADDR_WIDTH'(1);
      end
    end
  end

  // Next-state and RAM/handshake outputs. During INIT the write port is owned
  // by the fill sequence and both client interfaces are held off. In RUN the
  // write port is a straight pass-through of the client write, and the read
  // address goes to the RAM combinationally so data arrives on the next cycle.
  always_comb begin
    state_next = state;
    init_busy  = 1'b0;
    wr_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_raddr  = '0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = init_cnt;
        mem_wdata = INIT_VALUE;
        if (init_cnt == LAST_IDX) begin
          state_next = RUN;
        end
      end
      RUN: begin
        wr_ready  = 1'b1;
        mem_we    = wr_valid;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_raddr = rd_req_addr;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // Read flow control. A request is only accepted if the buffer can still
  // hold it once everything already in flight has landed, counting the pop
  // happening this cycle. This makes rd_req_ready depend combinationally on
  // rd_resp_ready, which is what lets a full buffer keep streaming.
  always_comb begin
    pop          = rd_resp_valid & rd_resp_ready;
    push         = s1_valid;
    pending      = {1'b0, fifo_occ} + {2'b00, s1_valid} - {2'b00, pop};
    rd_req_ready = (state == RUN) && (pending < 3'd2);
    rd_accept    = rd_req_valid & rd_req_ready;
    capture_data = fwd ? fwd_data : mem_rdata;
  end

  // Read pipeline stage. The RAM returns old data when a read and a write hit
  // the same address on the same edge, so a colliding write is remembered here
  // and substituted for the RAM data when the response is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      fwd      <= 1'b0;
      fwd_data <= '0;
    end else begin
      s1_valid <= rd_accept;
      fwd      <= rd_accept && wr_valid && wr_ready && (wr_addr == rd_req_addr);
      fwd_data <= wr_data;
    end
  end

  // Response buffer control. Pointers and occupancy are reset so in-flight
  // responses vanish on reset; push and pop on the same edge leave the
  // occupancy unchanged at any fill level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_occ    <= 2'd0;
    end else begin
      if (push) begin
        fifo_wr_ptr <= ~fifo_wr_ptr;
      end
      if (pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_occ <= fifo_occ + 2'd1;
        2'b01:   fifo_occ <= fifo_occ - 2'd1;
        default: fifo_occ <= fifo_occ;
      endcase
    end
  end

  // Response buffer storage. The data needs no reset because nothing reads a
  // slot before it has been written since the last reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[fifo_wr_ptr] <= capture_data;
    end
  end

  // Response outputs, with the data forced to zero while the buffer is empty.
  always_comb begin
    rd_resp_valid = (fifo_occ != 2'd0);
    rd_resp_data  = rd_resp_valid ? fifo_mem[fifo_rd_ptr] : '0;
  end

endmodule

// File: tb/tb_bram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bram_access_ctrl
//
// Directed bench for bram_access_ctrl with a behavioural 1R1W RAM attached.
// A shadow copy of the RAM contents predicts each read response at the
// moment the request is accepted; the prediction is queued and compared when
// the response is popped.
// ---------------------------------------------------------------------------
module tb_bram_access_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk;
  logic          reset_n;
  logic          init_busy;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_resp_valid;
  logic          rd_resp_ready;
  logic [DW-1:0] rd_resp_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] sbQ [$];

  int nCompared;
  int nMismatched;
  int nAccepted;

  bram_access_ctrl #(
    .BRAM_ADDR_WIDTH(AW),
    .BRAM_DATA_WIDTH(DW),
    .DATA_DEPTH     (DEPTH),
    .INIT_VALUE     ('0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init_busy    (init_busy),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_ready(rd_resp_ready),
    .rd_resp_data (rd_resp_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM preloaded with junk so the init fill has something visible to clear.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 32'hBAD0_0000 + i;
    end
  end

  // Behavioural RAM: 1-cycle read latency, old data on same-address collision.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_waddr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_raddr];
  end

  // Hard time limit so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts, asserts and reports.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then wait for the falling
  // edge where outputs are sampled.
  task automatic applyStimulus(input logic rv, input logic [AW-1:0] ra,
                               input logic wv, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic rr);
    rd_req_valid  = rv;
    rd_req_addr   = ra;
    wr_valid      = wv;
    wr_addr       = wa;
    wr_data       = wd;
    rd_resp_ready = rr;
    @(negedge clk);
  endtask

  // Scoreboard bookkeeping for the handshakes seen this cycle, then advance
  // to just after the next rising edge.
  task automatic scoreAndAdvance();
    logic [DW-1:0] expData;
    if (rd_resp_valid && rd_resp_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_resp", sbQ.size(), 1);
      end else begin
        expData = sbQ.pop_front();
        checkOutput("resp_data", rd_resp_data, expData);
      end
    end
    if (rd_req_valid && rd_req_ready) begin
      nAccepted++;
      if (wr_valid && wr_ready && (wr_addr == rd_req_addr)) begin
        sbQ.push_back(wr_data);
      end else begin
        sbQ.push_back(shadow[rd_req_addr]);
      end
    end
    if (wr_valid && wr_ready) begin
      shadow[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic rr);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, rr);
    scoreAndAdvance();
  endtask

  task automatic drainAll();
    for (int i = 0; i < 20; i++) begin
      if (sbQ.size() != 0) begin
        idleCycle(1'b1);
      end
    end
    checkOutput("drain_empty", sbQ.size(), 0);
  endtask

  task automatic runInitFill(input string phase);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 1'b1, 5'(i + 2), 32'hFFFF_0000 + i, 1'b1);
      checkOutput({phase, "_mem_we"}, mem_we, 1'b1);
      checkOutput({phase, "_mem_waddr"}, mem_waddr, i);
      checkOutput({phase, "_mem_wdata"}, mem_wdata, '0);
      checkOutput({phase, "_init_busy"}, init_busy, 1'b1);
      checkOutput({phase, "_rd_req_ready"}, rd_req_ready, 1'b0);
      checkOutput({phase, "_wr_ready"}, wr_ready, 1'b0);
      scoreAndAdvance();
    end
  endtask

  initial begin
    int accBase;
    logic [AW-1:0] bpAddr;

    nCompared   = 0;
    nMismatched = 0;
    nAccepted   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      shadow[i] = '0;
    end

    reset_n       = 1'b0;
    rd_req_valid  = 1'b0;
    rd_req_addr   = '0;
    wr_valid      = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    rd_resp_ready = 1'b0;

    // Reset values.
    @(negedge clk);
    checkOutput("rst_init_busy", init_busy, 1'b1);
    checkOutput("rst_rd_req_ready", rd_req_ready, 1'b0);
    checkOutput("rst_wr_ready", wr_ready, 1'b0);
    checkOutput("rst_rd_resp_valid", rd_resp_valid, 1'b0);
    checkOutput("rst_rd_resp_data", rd_resp_data, '0);
    checkOutput("rst_mem_we", mem_we, 1'b1);
    checkOutput("rst_mem_waddr", mem_waddr, '0);
    checkOutput("rst_mem_wdata", mem_wdata, '0);
    checkOutput("rst_mem_raddr", mem_raddr, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Init fill, with client traffic that must be ignored.
    $display("[TB] init fill");
    runInitFill("init");
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    checkOutput("run_init_busy", init_busy, 1'b0);
    checkOutput("run_wr_ready", wr_ready, 1'b1);
    checkOutput("run_rd_req_ready", rd_req_ready, 1'b1);
    checkOutput("init_nothing_accepted", nAccepted, 0);
    scoreAndAdvance();
    applyStimulus(1'b1, 5'd7, 1'b0, '0, '0, 1'b1);
    scoreAndAdvance();
    drainAll();

    // Basic write then read, with 2-cycle response latency.
    $display("[TB] basic write/read");
    applyStimulus(1'b0, '0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
    checkOutput("wr_mem_we", mem_we, 1'b1);
    checkOutput("wr_mem_waddr", mem_waddr, 5'd3);
    checkOutput("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    scoreAndAdvance();
    applyStimulus(1'b1, 5'd3, 1'b0, '0, '0, 1'b1);
    checkOutput("rd_mem_raddr", mem_raddr, 5'd3);
    checkOutput("rd_resp_valid_t0", rd_resp_valid, 1'b0);
    scoreAndAdvance();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    checkOutput("rd_resp_valid_t1", rd_resp_valid, 1'b0);
    scoreAndAdvance();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    checkOutput("rd_resp_valid_t2", rd_resp_valid, 1'b1);
    scoreAndAdvance();
    drainAll();

    // Forwarding of a same-cycle write, and no forwarding to another address.
    $display("[TB] forwarding");
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd5, 32'h1234_5678, 1'b1);
    scoreAndAdvance();
    applyStimulus(1'b1, 5'd6, 1'b1, 5'd5, 32'h55AA_55AA, 1'b1);
    scoreAndAdvance();
    applyStimulus(1'b1, 5'd5, 1'b0, '0, '0, 1'b1);
    scoreAndAdvance();
    drainAll();

    // Distinct contents for the streaming and backpressure reads.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 5'(i), 32'h1111_1111 * (i + 1), 1'b1);
      scoreAndAdvance();
    end

    // Streaming: ten back-to-back reads, responses with no bubble.
    $display("[TB] streaming");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(k < 10, 5'(k), 1'b0, '0, '0, 1'b1);
      if (k < 10) begin
        checkOutput("stream_req_ready", rd_req_ready, 1'b1);
      end
      checkOutput("stream_resp_valid", rd_resp_valid, k >= 2);
      scoreAndAdvance();
    end
    drainAll();

    // Backpressure: exactly two accepts while the consumer stalls.
    $display("[TB] backpressure");
    accBase = nAccepted;
    for (int k = 0; k < 6; k++) begin
      bpAddr = 5'(10 + nAccepted - accBase);
      applyStimulus(1'b1, bpAddr, 1'b0, '0, '0, 1'b0);
      if (k >= 2) begin
        checkOutput("bp_req_ready_low", rd_req_ready, 1'b0);
      end
      scoreAndAdvance();
    end
    checkOutput("bp_accept_count", nAccepted - accBase, 2);
    checkOutput("bp_queue_depth", sbQ.size(), 2);
    for (int k = 0; k < 4; k++) begin
      bpAddr = 5'(10 + nAccepted - accBase);
      applyStimulus(1'b1, bpAddr, 1'b0, '0, '0, 1'b1);
      checkOutput("bp_resume_ready", rd_req_ready, 1'b1);
      scoreAndAdvance();
    end
    checkOutput("bp_total_accepts", nAccepted - accBase, 6);
    drainAll();

    // Reset with two responses buffered.
    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 5'd0, 1'b0, '0, '0, 1'b0);
    scoreAndAdvance();
    applyStimulus(1'b1, 5'd1, 1'b0, '0, '0, 1'b0);
    scoreAndAdvance();
    idleCycle(1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("pre_rst_resp_valid", rd_resp_valid, 1'b1);
    checkOutput("pre_rst_queue_depth", sbQ.size(), 2);
    scoreAndAdvance();
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_resp_valid", rd_resp_valid, 1'b0);
    checkOutput("midrst_init_busy", init_busy, 1'b1);
    checkOutput("midrst_rd_req_ready", rd_req_ready, 1'b0);
    sbQ.delete();
    for (int i = 0; i < DEPTH; i++) begin
      shadow[i] = '0;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    runInitFill("reinit");
    applyStimulus(1'b1, 5'd3, 1'b0, '0, '0, 1'b1);
    checkOutput("reinit_rd_req_ready", rd_req_ready, 1'b1);
    scoreAndAdvance();
    drainAll();

    checkOutput("final_sb_empty", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
